// File: rtl/key_debounce_io.sv
// key_debounce_io
//   Debounced push-button input. A raw, active-low key pin is brought into the
//   CLK domain by a two-flop synchronizer. A four-state FSM then accepts a
//   press or release only after the synchronized level has held steady for
//   T_DEBOUNCE cycles. The FSM states are IDLE, PRESS_DB, HELD and RELEASE_DB.
//
//   Optional feature: define KEY_LONG_PRESS_EN to build the hold counter and
//   the KEY_LONG strobe. Without it KEY_LONG is tied to 0.
//
//   Parameters
//     T_DEBOUNCE  debounce window in CLK cycles (2..2^23-1)
//     T_LONG      hold time for long-press detection in CLK cycles (2..2^26-1)
//   Ports
//     CLK          system clock; all logic on its rising edge
//     RST          asynchronous reset, active-high
//     KEY_IN       raw key pin, active-low, asynchronous to CLK
//     KEY_LEVEL    debounced level, 1 = pressed
//     KEY_PRESS    one-cycle strobe on an accepted press
//     KEY_RELEASE  one-cycle strobe on an accepted release
//     KEY_LONG     one-cycle strobe when the hold reaches T_LONG cycles
//     PRESS_CNT    count of accepted presses, wraps at 256
module key_debounce_io #(
  parameter logic [22:0] T_DEBOUNCE = 23'd1_000_000,
  parameter logic [25:0] T_LONG     = 26'd50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_IN,
  output logic       KEY_LEVEL,
  output logic       KEY_PRESS,
  output logic       KEY_RELEASE,
  output logic       KEY_LONG,
  output logic [7:0] PRESS_CNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_RELEASE_DB
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_sync;
  logic        w_key_s;
  logic [22:0] r_db_cnt;
  logic [22:0] w_db_cnt_nxt;
  logic        w_db_done;
  logic        w_press;
  logic        w_release;
  logic        r_level;
  logic        r_press;
  logic        r_release;
  logic [7:0]  r_press_cnt;

  // Both synchronizer flops reset to the released level, so a key held
  // through reset is seen as a fresh edge once reset drops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], KEY_IN};
  end

  assign w_key_s   = ~r_sync[1];
  assign w_db_done = (r_db_cnt == T_DEBOUNCE - 23'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_db_cnt <= w_db_cnt_nxt;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_press      = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_key_s) begin
          w_next       = S_PRESS_DB;
          w_db_cnt_nxt = '0;
        end
      end
      S_PRESS_DB: begin
        if (!w_key_s) begin
          w_next = S_IDLE;
        end else if (w_db_done) begin
          w_next  = S_HELD;
          w_press = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 23'd1;
        end
      end
      S_HELD: begin
        if (!w_key_s) begin
          w_next       = S_RELEASE_DB;
          w_db_cnt_nxt = '0;
        end
      end
      S_RELEASE_DB: begin
        if (w_key_s) begin
          w_next = S_HELD;
        end else if (w_db_done) begin
          w_next    = S_IDLE;
          w_release = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 23'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, so they line up with
  // the state they describe and have no combinational path from KEY_IN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_level   <= (w_next == S_HELD) || (w_next == S_RELEASE_DB);
      r_press   <= w_press;
      r_release <= w_release;
      if (w_press) r_press_cnt <= r_press_cnt + 8'd1;
    end
  end

  assign KEY_LEVEL   = r_level;
  assign KEY_PRESS   = r_press;
  assign KEY_RELEASE = r_release;
  assign PRESS_CNT   = r_press_cnt;

`ifdef KEY_LONG_PRESS_EN
  logic [25:0] r_hold_cnt;
  logic        r_long;
  logic        w_holding;

  assign w_holding = (r_state == S_HELD) || (r_state == S_RELEASE_DB);

  // The hold counter parks at T_LONG after firing, which gives exactly one
  // strobe per hold. A release bounce back to HELD keeps the count. A pulse
  // that would land on the release edge is dropped, because entering IDLE
  // clears the counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_cnt <= '0;
      r_long     <= 1'b0;
    end else if (w_press || (w_next == S_IDLE)) begin
      r_hold_cnt <= '0;
      r_long     <= 1'b0;
    end else if (w_holding) begin
      r_long <= (r_hold_cnt == T_LONG - 26'd1);
      if (r_hold_cnt != T_LONG) r_hold_cnt <= r_hold_cnt + 26'd1;
    end else begin
      r_long <= 1'b0;
    end
  end

  assign KEY_LONG = r_long;
`else
  logic w_unused_t_long;
  assign w_unused_t_long = ^T_LONG;
  assign KEY_LONG        = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_io.sv
module tb_key_debounce_io;

  localparam int TDB = 4;
  localparam int TLG = 10;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic       KEY_IN;
  logic       KEY_LEVEL;
  logic       KEY_PRESS;
  logic       KEY_RELEASE;
  logic       KEY_LONG;
  logic [7:0] PRESS_CNT;

  key_debounce_io #(
    .T_DEBOUNCE(23'(TDB)),
    .T_LONG    (26'(TLG))
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY_IN     (KEY_IN),
    .KEY_LEVEL  (KEY_LEVEL),
    .KEY_PRESS  (KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_LONG   (KEY_LONG),
    .PRESS_CNT  (PRESS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. The pin passes through a two-sample delay and is
  // inverted to give the pressed value. The debounced level flips once the
  // pressed value has disagreed with it on TDB+1 consecutive clocks. The
  // long strobe fires TLG clocks after a press if the key is still down.
  bit       m_q1, m_q2;
  bit       m_lvl;
  int       m_run;
  int       m_age;
  bit [7:0] m_cnt;

  task automatic model_reset();
    m_q1 = 1'b1; m_q2 = 1'b1; m_lvl = 1'b0;
    m_run = 0; m_age = 0; m_cnt = '0;
  endtask

  task automatic model_edge(input bit raw, output bit ep, output bit er, output bit el);
    bit seen;
    seen = !m_q2;
    m_q2 = m_q1;
    m_q1 = raw;
    ep = 1'b0; er = 1'b0; el = 1'b0;
    if (seen != m_lvl) m_run++;
    else               m_run = 0;
    if (m_run == TDB + 1) begin
      m_lvl = !m_lvl;
      m_run = 0;
      if (m_lvl) begin
        ep = 1'b1;
        m_cnt++;
        m_age = 0;
      end else begin
        er = 1'b1;
      end
    end else if (m_lvl) begin
      m_age++;
      if (m_age == TLG) el = LONG_EN;
    end
  endtask

  int cyc = 0;
  int n_press, n_rel, n_long;
  int last_press, last_rel, last_long;

  task automatic clr_stats();
    n_press = 0; n_rel = 0; n_long = 0;
    last_press = -1; last_rel = -1; last_long = -1;
  endtask

  // Called at a falling edge; drives the pin, advances one rising edge,
  // checks every output against the model and returns at the next falling edge.
  task automatic step(input logic k);
    bit ep, er, el;
    KEY_IN = k;
    @(posedge CLK);
    cyc++;
    model_edge(k, ep, er, el);
    #1;
    chk("level",   32'(KEY_LEVEL),   32'(m_lvl));
    chk("press",   32'(KEY_PRESS),   32'(ep));
    chk("release", 32'(KEY_RELEASE), 32'(er));
    chk("long",    32'(KEY_LONG),    32'(el));
    chk("cnt",     32'(PRESS_CNT),   32'(m_cnt));
    if (KEY_PRESS)   begin n_press++; last_press = cyc; end
    if (KEY_RELEASE) begin n_rel++;   last_rel   = cyc; end
    if (KEY_LONG)    begin n_long++;  last_long  = cyc; end
    @(negedge CLK);
  endtask

  task automatic steps(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_level",   32'(KEY_LEVEL),   0);
    chk("rst_press",   32'(KEY_PRESS),   0);
    chk("rst_release", 32'(KEY_RELEASE), 0);
    chk("rst_long",    32'(KEY_LONG),    0);
    chk("rst_cnt",     32'(PRESS_CNT),   0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0;
    RST = 1'b1;
    KEY_IN = 1'b1;
    model_reset();
    clr_stats();
    @(negedge CLK);
    do_reset();

    // Clean press then clean release.
    clr_stats();
    c0 = cyc + 1;
    steps(1'b0, 20);
    chk("clean_press_lat", 32'(last_press - c0), 6);
    chk("clean_npress", 32'(n_press), 1);
    chk("clean_cnt", 32'(PRESS_CNT), 1);
    chk("clean_level_on", 32'(KEY_LEVEL), 1);
    c0 = cyc + 1;
    steps(1'b1, 20);
    chk("clean_rel_lat", 32'(last_rel - c0), 6);
    chk("clean_nrel", 32'(n_rel), 1);
    chk("clean_level_off", 32'(KEY_LEVEL), 0);

    // Press bounce.
    do_reset();
    clr_stats();
    steps(1'b0, 3); steps(1'b1, 1); steps(1'b0, 3); steps(1'b1, 1);
    chk("bounce_quiet", 32'(n_press), 0);
    c0 = cyc + 1;
    steps(1'b0, 20);
    chk("bounce_npress", 32'(n_press), 1);
    chk("bounce_lat", 32'(last_press - c0), 6);
    chk("bounce_cnt", 32'(PRESS_CNT), 1);

    // Release bounce while held.
    clr_stats();
    steps(1'b1, 2);
    steps(1'b0, 10);
    chk("rbounce_nrel", 32'(n_rel), 0);
    chk("rbounce_level", 32'(KEY_LEVEL), 1);
    steps(1'b1, 10);

    // Long press.
    do_reset();
    clr_stats();
    steps(1'b0, 30);
    chk("long_count", 32'(n_long), 32'(LONG_EN));
    if (LONG_EN) chk("long_lat", 32'(last_long - last_press), 10);
    steps(1'b1, 10);

    // Press counter wrap.
    do_reset();
    clr_stats();
    for (int i = 0; i < 256; i++) begin
      steps(1'b0, 8);
      steps(1'b1, 8);
    end
    chk("wrap_npress", 32'(n_press), 256);
    chk("wrap_cnt", 32'(PRESS_CNT), 0);

    // Reset in the middle of a hold, key still down.
    do_reset();
    steps(1'b0, 10);
    chk("midhold_level", 32'(KEY_LEVEL), 1);
    do_reset();
    clr_stats();
    c0 = cyc + 1;
    steps(1'b0, 10);
    chk("midhold_lat", 32'(last_press - c0), 6);
    chk("midhold_cnt", 32'(PRESS_CNT), 1);
    chk("midhold_nrel", 32'(n_rel), 0);
    steps(1'b1, 10);

    // Random bouncy segments.
    for (int s = 0; s < 120; s++) begin
      steps(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    steps(1'b1, 12);
    chk("rand_final_level", 32'(KEY_LEVEL), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
